// File: rtl/mult_arbiter_if.sv
// mult_arbiter_if: request, multiplier and response bundle for mult_arbiter.
// slave = arbiter side; master = requesters, multiplier and consumer side.
interface mult_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int IDW     = 2
) ();

  logic                   issue_en;
  logic [NUM_REQ-1:0]     req_valid;
  logic [NUM_REQ-1:0]     req_ready;
  logic [32*NUM_REQ-1:0]  req_a;
  logic [32*NUM_REQ-1:0]  req_b;
  logic [31:0]            mul_a;
  logic [31:0]            mul_b;
  logic [31:0]            mul_product;
  logic                   rsp_valid;
  logic [IDW-1:0]         rsp_id;
  logic [31:0]            rsp_product;
  logic                   busy;
  logic [15:0]            issue_count;

  modport slave (
    input  issue_en,
    input  req_valid,
    input  req_a,
    input  req_b,
    input  mul_product,
    output req_ready,
    output mul_a,
    output mul_b,
    output rsp_valid,
    output rsp_id,
    output rsp_product,
    output busy,
    output issue_count
  );

  modport master (
    output issue_en,
    output req_valid,
    output req_a,
    output req_b,
    output mul_product,
    input  req_ready,
    input  mul_a,
    input  mul_b,
    input  rsp_valid,
    input  rsp_id,
    input  rsp_product,
    input  busy,
    input  issue_count
  );

endinterface

// File: rtl/mult_arbiter.sv
// mult_arbiter: round-robin sharing of one pipelined fp32 multiplier.
// Ports: clock, reset (sync, high); bus (slave): grants, operands, tagged results.
module mult_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int MUL_LATENCY = 8,
  parameter int IDW         = 2
) (
  input  logic          clock,
  input  logic          reset,
  mult_arbiter_if.slave bus
);

  // Tag stages follow the operand register, so a grant at E0
  // surfaces after edge E0+MUL_LATENCY+1, in step with the product.
  localparam int TD = MUL_LATENCY + 1;

  logic [IDW-1:0] rr_ptr;
  logic           gnt_hit;
  logic [IDW-1:0] gnt_id;
  logic           hs;
  logic [31:0]    gnt_a;
  logic [31:0]    gnt_b;

  logic [31:0]    op_a;
  logic [31:0]    op_b;
  logic           op_valid;
  logic [IDW-1:0] op_id;

  logic [TD-1:0]  tag_v;
  logic [IDW-1:0] tag_id [TD];
  logic [15:0]    cnt;

  // First requester at or above rr_ptr, wrapping.
  always_comb begin
    int             j;
    logic [IDW-1:0] idx;
    gnt_hit = 1'b0;
    gnt_id  = '0;
    j       = 0;
    idx     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = int'(rr_ptr) + k;
      if (j >= NUM_REQ) begin
        j = j - NUM_REQ;
      end
      idx = IDW'(j);
      if (!gnt_hit && bus.req_valid[idx]) begin
        gnt_hit = 1'b1;
        gnt_id  = idx;
      end
    end
  end

  assign hs = gnt_hit & bus.issue_en & ~reset;

  always_comb begin
    bus.req_ready = '0;
    if (hs) begin
      bus.req_ready[gnt_id] = 1'b1;
    end
  end

  always_comb begin
    gnt_a = '0;
    gnt_b = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (IDW'(i) == gnt_id) begin
        gnt_a = bus.req_a[32*i +: 32];
        gnt_b = bus.req_b[32*i +: 32];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rr_ptr   <= '0;
      op_a     <= '0;
      op_b     <= '0;
      op_valid <= 1'b0;
      op_id    <= '0;
      tag_v    <= '0;
      cnt      <= '0;
      for (int k = 0; k < TD; k++) begin
        tag_id[k] <= '0;
      end
    end else begin
      if (hs) begin
        if (gnt_id == IDW'(NUM_REQ - 1)) begin
          rr_ptr <= '0;
        end else begin
          rr_ptr <= gnt_id + 1'b1;
        end
        cnt <= cnt + 16'd1;
      end
      // Idle cycles feed zero operands as a bubble.
      op_a     <= hs ? gnt_a : '0;
      op_b     <= hs ? gnt_b : '0;
      op_valid <= hs;
      op_id    <= hs ? gnt_id : '0;
      tag_v    <= {tag_v[TD-2:0], op_valid};
      tag_id[0] <= op_id;
      for (int k = 1; k < TD; k++) begin
        tag_id[k] <= tag_id[k-1];
      end
    end
  end

  assign bus.mul_a       = op_a;
  assign bus.mul_b       = op_b;
  assign bus.rsp_valid   = tag_v[TD-1];
  assign bus.rsp_id      = tag_id[TD-1];
  assign bus.rsp_product = bus.mul_product;
  assign bus.busy        = op_valid | (|tag_v);
  assign bus.issue_count = cnt;

endmodule

// File: tb/tb_mult_arbiter.sv
// tb_mult_arbiter: directed and random checks of mult_arbiter.
// Queue-based reference: grants by round-robin search, results due 9 edges on.
module tb_mult_arbiter;

  localparam int N  = 4;
  localparam int ML = 8;
  localparam int IW = 2;

  logic clock = 1'b0;
  logic reset;

  always #5 clock = ~clock;

  mult_arbiter_if #(.NUM_REQ(N), .IDW(IW)) bus ();

  mult_arbiter #(
    .NUM_REQ(N),
    .MUL_LATENCY(ML),
    .IDW(IW)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );

  function automatic logic [31:0] fmul(input logic [31:0] a,
                                       input logic [31:0] b);
    logic        s;
    logic [47:0] p;
    logic [22:0] m;
    logic        g;
    logic        st;
    logic [23:0] mr;
    int          e;
    s = a[31] ^ b[31];
    if (a[30:23] == 8'd0 || b[30:23] == 8'd0) return {s, 31'h0};
    p = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
    e = int'(a[30:23]) + int'(b[30:23]) - 127;
    if (p[47]) begin
      e++;
      m  = p[46:24];
      g  = p[23];
      st = |p[22:0];
    end else begin
      m  = p[45:23];
      g  = p[22];
      st = |p[21:0];
    end
    mr = {1'b0, m} + 24'(g && (st || m[0]));
    if (mr[23]) e++;
    return {s, e[7:0], mr[22:0]};
  endfunction

  // Stand-in multiplier: captures mul_a/mul_b, product ML edges later.
  logic [31:0] mpipe [ML+1];
  always @(posedge clock) begin
    mpipe[0] <= fmul(bus.mul_a, bus.mul_b);
    for (int k = 1; k <= ML; k++) mpipe[k] <= mpipe[k-1];
  end
  assign bus.mul_product = mpipe[ML];

  typedef struct {
    int          due;
    int          id;
    logic [31:0] prod;
  } exp_t;

  exp_t        exp_q[$];
  int          seen_ids[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          rr = 0;
  int          cnt = 0;
  logic [31:0] exp_mula = '0;
  logic [31:0] exp_mulb = '0;
  logic [31:0] last_prod = '0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rand_fp();
    logic [31:0] r;
    r[31]    = 1'($urandom_range(0, 1));
    r[30:23] = 8'($urandom_range(100, 150));
    r[22:0]  = 23'($urandom);
    return r;
  endfunction

  task automatic set_op(input int i, input logic [31:0] a,
                        input logic [31:0] b);
    bus.req_a[32*i +: 32] = a;
    bus.req_b[32*i +: 32] = b;
  endtask

  task automatic rand_ops();
    for (int i = 0; i < N; i++) set_op(i, rand_fp(), rand_fp());
  endtask

  // Called at a negedge with inputs already driven.
  task automatic step();
    int          g;
    logic [N-1:0] er;
    logic [31:0] a;
    logic [31:0] b;
    exp_t        e;
    #1;
    g  = -1;
    er = '0;
    if (!reset && bus.issue_en) begin
      for (int k = 0; k < N; k++) begin
        int j;
        j = (rr + k) % N;
        if (g < 0 && bus.req_valid[j]) g = j;
      end
    end
    if (g >= 0) er[g] = 1'b1;
    chk("req_ready", 32'(bus.req_ready), 32'(er));
    if (reset) begin
      exp_q.delete();
      rr = 0;
      cnt = 0;
      exp_mula = '0;
      exp_mulb = '0;
    end else if (g >= 0) begin
      a = bus.req_a[32*g +: 32];
      b = bus.req_b[32*g +: 32];
      e.due  = cyc + 10;
      e.id   = g;
      e.prod = fmul(a, b);
      exp_q.push_back(e);
      rr = (g + 1) % N;
      cnt = (cnt + 1) % 65536;
      exp_mula = a;
      exp_mulb = b;
    end else begin
      exp_mula = '0;
      exp_mulb = '0;
    end
    @(posedge clock);
    cyc++;
    @(negedge clock);
    chk("busy", 32'(bus.busy), 32'(exp_q.size() > 0));
    if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      chk("rsp_valid", 32'(bus.rsp_valid), 32'd1);
      chk("rsp_id", 32'(bus.rsp_id), 32'(exp_q[0].id));
      chk("rsp_product", bus.rsp_product, exp_q[0].prod);
      void'(exp_q.pop_front());
    end else begin
      chk("rsp_valid", 32'(bus.rsp_valid), 32'd0);
    end
    if (bus.rsp_valid === 1'b1) begin
      seen_ids.push_back(int'(bus.rsp_id));
      last_prod = bus.rsp_product;
    end
    chk("issue_count", 32'(bus.issue_count), 32'(cnt));
    chk("mul_a", bus.mul_a, exp_mula);
    chk("mul_b", bus.mul_b, exp_mulb);
  endtask

  initial begin
    reset = 1'b1;
    bus.issue_en  = 1'b1;
    bus.req_valid = '1;
    rand_ops();
    @(negedge clock);
    step();
    step();

    // single op from requester 2
    reset = 1'b0;
    set_op(2, 32'h40400000, 32'h40000000);
    bus.req_valid = 4'b0100;
    seen_ids.delete();
    step();
    bus.req_valid = '0;
    repeat (11) step();
    chk("single_nrsp", 32'(seen_ids.size()), 32'd1);
    if (seen_ids.size() > 0) chk("single_id", 32'(seen_ids[0]), 32'd2);
    chk("single_prod", last_prod, 32'h40C00000);
    chk("single_cnt", 32'(bus.issue_count), 32'd1);

    // all four held valid from reset
    reset = 1'b1;
    step();
    reset = 1'b0;
    rand_ops();
    bus.req_valid = 4'hF;
    seen_ids.delete();
    repeat (8) step();
    bus.req_valid = '0;
    repeat (12) step();
    chk("rr_nrsp", 32'(seen_ids.size()), 32'd8);
    foreach (seen_ids[i]) chk("rr_order", 32'(seen_ids[i]), 32'(i % 4));

    // requesters 1 and 3 with rr_ptr at 2
    reset = 1'b1;
    step();
    reset = 1'b0;
    rand_ops();
    seen_ids.delete();
    bus.req_valid = 4'b0010;
    step();
    bus.req_valid = 4'b1010;
    repeat (4) step();
    bus.req_valid = '0;
    repeat (12) step();
    chk("skip_nrsp", 32'(seen_ids.size()), 32'd5);
    foreach (seen_ids[i])
      chk("skip_order", 32'(seen_ids[i]), (i % 2 == 0) ? 32'd1 : 32'd3);

    // issue_en low while operations drain
    seen_ids.delete();
    bus.req_valid = 4'hF;
    repeat (3) step();
    bus.issue_en = 1'b0;
    repeat (5) step();
    bus.req_valid = '0;
    repeat (12) step();
    bus.issue_en = 1'b1;
    chk("drain_nrsp", 32'(seen_ids.size()), 32'd3);

    // reset in flight discards the op
    reset = 1'b1;
    step();
    reset = 1'b0;
    seen_ids.delete();
    set_op(0, 32'h3FC00000, 32'h40000000);
    bus.req_valid = 4'b0001;
    step();
    bus.req_valid = '0;
    repeat (3) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    repeat (12) step();
    chk("rst_nrsp", 32'(seen_ids.size()), 32'd0);
    chk("rst_cnt", 32'(bus.issue_count), 32'd0);

    // random traffic
    repeat (400) begin
      rand_ops();
      bus.req_valid = 4'($urandom);
      bus.issue_en  = ($urandom_range(0, 3) != 0);
      reset         = ($urandom_range(0, 49) == 0);
      step();
    end
    reset = 1'b0;
    bus.issue_en  = 1'b1;
    bus.req_valid = '0;
    repeat (12) step();

    // issue_count wrap
    reset = 1'b1;
    step();
    reset = 1'b0;
    bus.req_valid = 4'b0001;
    repeat (65535) step();
    chk("wrap_pre", 32'(bus.issue_count), 32'h0000FFFF);
    step();
    chk("wrap_post", 32'(bus.issue_count), 32'd0);
    bus.req_valid = '0;
    repeat (12) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
